// File: rtl/krv_uart_pkg.sv
// Shared definitions for the krv_e UART receive path: FSM states, framing constants
// and the parity helper used when UART_RX_PARITY_EN is defined.
package krv_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int OVERSAMPLE    = 16;
  localparam int MID_SAMPLE    = 8;
  localparam int MAX_DATA_BITS = 8;

  // 1 when data plus parity bit do not give the requested parity (even1 = 0 asks for odd).
  function automatic logic parity_mismatch(input logic [MAX_DATA_BITS-1:0] data,
                                           input logic par_bit,
                                           input logic even1);
    return (^data) ^ par_bit ^ ~even1;
  endfunction

endpackage

// File: rtl/krv_uart_sync2.sv
// Two-flop synchroniser for the asynchronous UART_RX line; both stages reset to the
// idle-high level so a reset never looks like a start bit.
module krv_uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/krv_uart_rx.sv
// UART receiver: 16x oversampled deserialiser feeding a one-entry holding register.
// Parity support is compiled in only when UART_RX_PARITY_EN is defined.
module krv_uart_rx
  import krv_uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int MID_SAMPLE = 8
) (
  input  logic       ACLK,
  input  logic       ARESETn,
  input  logic       UART_RX,
  input  logic       rx_sample_pulse,
  input  logic       data_bits,
  input  logic       parity_en,
  input  logic       parity_odd0_even1,
  input  logic       rx_data_reg_rd,
  output logic [7:0] rx_data,
  output logic       rx_data_read_valid,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       overflow,
  output logic [2:0] rx_state_dbg
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  // The falling-edge tick is tick 0 and tick_q lags by one, so tick MID_SAMPLE sees MID_SAMPLE-1.
  localparam logic [TW-1:0] TICK_MID  = TW'(MID_SAMPLE - 1);

  logic rx_s;

  krv_uart_sync2 u_sync (
    .clk (ACLK),
    .rst (ARESETn),
    .d   (UART_RX),
    .q   (rx_s)
  );

  rx_state_e                state_q, state_d;
  logic [TW-1:0]            tick_q, tick_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic                     line_prev_q, line_prev_d;
  logic                     cfg_8bit_q, cfg_8bit_d;
  logic [7:0]               data_q, data_d;
  logic                     ready_q, ready_d;
  logic                     perr_q, perr_d;
  logic                     ovf_q, ovf_d;
  logic                     valid_q, valid_d;
  logic                     commit;
  logic                     commit_perr;
  logic                     rd_ok;
  logic [2:0]               last_bit;

`ifdef UART_RX_PARITY_EN
  logic cfg_par_q, cfg_par_d;
  logic cfg_even_q, cfg_even_d;
  logic perr_frame_q, perr_frame_d;
  assign commit_perr = perr_frame_q;
`else
  logic unused_cfg;
  assign unused_cfg  = parity_en ^ parity_odd0_even1;
  assign commit_perr = 1'b0;
`endif

  assign last_bit = cfg_8bit_q ? 3'd7 : 3'd6;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    line_prev_d = line_prev_q;
    cfg_8bit_d  = cfg_8bit_q;
    commit      = 1'b0;
`ifdef UART_RX_PARITY_EN
    cfg_par_d    = cfg_par_q;
    cfg_even_d   = cfg_even_q;
    perr_frame_d = perr_frame_q;
`endif
    if (rx_sample_pulse) begin
      line_prev_d = rx_s;
      tick_d      = tick_q + TW'(1);
      case (state_q)
        IDLE: begin
          if (line_prev_q && !rx_s) begin
            state_d    = START;
            tick_d     = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
            cfg_8bit_d = data_bits;
`ifdef UART_RX_PARITY_EN
            cfg_par_d    = parity_en;
            cfg_even_d   = parity_odd0_even1;
            perr_frame_d = 1'b0;
`endif
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            state_d = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_d             = '0;
            shift_d[bit_cnt_q] = rx_s;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == last_bit) begin
`ifdef UART_RX_PARITY_EN
              state_d = cfg_par_q ? PARITY : STOP;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_q == TICK_LAST) begin
            tick_d       = '0;
            perr_frame_d = parity_mismatch(shift_q, rx_s, cfg_even_q);
            state_d      = STOP;
          end
        end
`endif
        STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            commit  = rx_s;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Read handshake: a strobe only counts while rx_ready is 1; it clears ready/parity/overflow
  // and answers with a one-cycle rx_data_read_valid. A commit in the same cycle wins for ready.
  always_comb begin
    rd_ok   = rx_data_reg_rd && ready_q;
    data_d  = data_q;
    ready_d = ready_q;
    perr_d  = perr_q;
    ovf_d   = ovf_q;
    valid_d = rd_ok;
    if (rd_ok) begin
      ready_d = 1'b0;
      perr_d  = 1'b0;
      ovf_d   = 1'b0;
    end
    if (commit) begin
      data_d  = shift_q;
      ready_d = 1'b1;
      perr_d  = commit_perr;
      if (ready_q && !rd_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      line_prev_q <= 1'b1;
      cfg_8bit_q  <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      perr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      valid_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      cfg_par_q    <= 1'b0;
      cfg_even_q   <= 1'b0;
      perr_frame_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      line_prev_q <= line_prev_d;
      cfg_8bit_q  <= cfg_8bit_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      perr_q      <= perr_d;
      ovf_q       <= ovf_d;
      valid_q     <= valid_d;
`ifdef UART_RX_PARITY_EN
      cfg_par_q    <= cfg_par_d;
      cfg_even_q   <= cfg_even_d;
      perr_frame_q <= perr_frame_d;
`endif
    end
  end

  assign rx_data            = data_q;
  assign rx_ready           = ready_q;
  assign parity_err         = perr_q;
  assign overflow           = ovf_q;
  assign rx_data_read_valid = valid_q;
  assign rx_state_dbg       = state_q;

endmodule

// File: tb/tb_krv_uart_rx.sv
// Bench for krv_uart_rx: drives whole UART frames bit by bit and scores the holding
// register against a frame-level model. Parity frames are sent only when UART_RX_PARITY_EN is defined.
module tb_krv_uart_rx;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic       UART_RX = 1'b1;
  logic       rx_sample_pulse = 1'b0;
  logic       data_bits = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd0_even1 = 1'b0;
  logic       rx_data_reg_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_data_read_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       overflow;
  logic [2:0] rx_state_dbg;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  krv_uart_rx dut (
    .ACLK               (ACLK),
    .ARESETn            (ARESETn),
    .UART_RX            (UART_RX),
    .rx_sample_pulse    (rx_sample_pulse),
    .data_bits          (data_bits),
    .parity_en          (parity_en),
    .parity_odd0_even1  (parity_odd0_even1),
    .rx_data_reg_rd     (rx_data_reg_rd),
    .rx_data            (rx_data),
    .rx_data_read_valid (rx_data_read_valid),
    .rx_ready           (rx_ready),
    .parity_err         (parity_err),
    .overflow           (overflow),
    .rx_state_dbg       (rx_state_dbg)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int tick_per = 16;
  int n_checks = 0;
  int n_bad    = 0;

  // scoreboard: committed bytes (newest last) and model of the status flags
  logic [7:0] exp_q[$];
  bit m_ready, m_perr, m_ovf, m_valid;

  localparam logic [2:0] ST_IDLE = 3'(krv_uart_pkg::IDLE);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eb;
    eb = (exp_q.size() == 0) ? 8'h00 : exp_q[$];
    check_eq({tag, ".rx_data"}, 32'(rx_data), 32'(eb));
    check_eq({tag, ".rx_ready"}, 32'(rx_ready), 32'(m_ready));
    check_eq({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check_eq({tag, ".read_valid"}, 32'(rx_data_read_valid), 32'(m_valid));
  endtask

  // Frame-level model of one cycle of the holding register: an effective read first, then a commit.
  task automatic model_step(input bit rd, input bit commit, input logic [7:0] byte_v, input bit perr_v);
    bit hit;
    hit = rd && m_ready;
    m_valid = hit;
    if (hit) begin
      m_ready = 1'b0;
      m_perr  = 1'b0;
      m_ovf   = 1'b0;
    end
    if (commit) begin
      if (m_ready) m_ovf = 1'b1;
      exp_q.push_back(byte_v);
      if (exp_q.size() > 1) void'(exp_q.pop_front());
      m_ready = 1'b1;
      m_perr  = perr_v;
    end
  endtask

  // driver tasks
  task automatic do_tick(input bit rd_too);
    for (int i = 0; i < tick_per; i++) begin
      @(negedge ACLK);
      rx_sample_pulse = (i == tick_per - 1);
      rx_data_reg_rd  = rd_too && (i == tick_per - 1);
    end
  endtask

  task automatic line_ticks(input logic v, input int n);
    UART_RX = v;
    repeat (n) do_tick(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit b8, input bit pe, input bit ev,
                            input logic pbit, input logic stop, input bit rd_cc);
    int nb;
    bit has_par;
    bit perr_v;
    logic [7:0] dm;
    nb      = b8 ? 8 : 7;
    has_par = pe && PAR_BUILD;
    dm      = b8 ? d : {1'b0, d[6:0]};
    perr_v  = has_par && ((($countones(dm) + int'(pbit)) % 2) != (ev ? 0 : 1));
    m_valid = 1'b0;
    data_bits = b8;
    parity_en = pe;
    parity_odd0_even1 = ev;
    line_ticks(1'b1, 2);
    line_ticks(1'b0, 16);
    // the frame configuration is captured at the start bit; wiggling it now must not matter
    data_bits = 1'($urandom_range(0, 1));
    parity_en = 1'($urandom_range(0, 1));
    parity_odd0_even1 = 1'($urandom_range(0, 1));
    for (int i = 0; i < nb; i++) line_ticks(dm[i], 16);
    if (has_par) line_ticks(pbit, 16);
    line_ticks(stop, 8);
    @(negedge ACLK);
    rx_sample_pulse = 1'b0;
    check_all("pre_stop");
    do_tick(rd_cc);
    @(negedge ACLK);
    rx_sample_pulse = 1'b0;
    rx_data_reg_rd  = 1'b0;
    model_step(rd_cc, stop == 1'b1, dm, perr_v);
    check_all("stop");
    check_eq("state_after_stop", 32'(rx_state_dbg), 32'(ST_IDLE));
    m_valid = 1'b0;
    repeat (7) do_tick(1'b0);
    UART_RX = 1'b1;
  endtask

  task automatic do_read();
    @(negedge ACLK);
    rx_sample_pulse = 1'b0;
    rx_data_reg_rd  = 1'b1;
    @(negedge ACLK);
    rx_data_reg_rd = 1'b0;
    model_step(1'b1, 1'b0, 8'h00, 1'b0);
    check_all("read");
    @(negedge ACLK);
    m_valid = 1'b0;
    check_eq("read_valid_one_cycle", 32'(rx_data_read_valid), 32'(0));
  endtask

  task automatic do_reset(input int cyc);
    @(negedge ACLK);
    ARESETn = 1'b1;
    UART_RX = 1'b1;
    rx_sample_pulse = 1'b0;
    rx_data_reg_rd  = 1'b0;
    repeat (cyc) @(negedge ACLK);
    ARESETn = 1'b0;
    m_ready = 1'b0;
    m_perr  = 1'b0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    exp_q.delete();
    check_all("reset");
    check_eq("reset_state", 32'(rx_state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);

    // 8N1 0x55 with a 16-cycle tick
    tick_per = 16;
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_read();

    tick_per = 4;
    // 7E1 0x41, good then bad parity
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_read();
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    do_read();
    // 8O1 0xFF, good then bad parity
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    do_read();
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_read();

    // overflow on two unread frames
    send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_read();
    // read with nothing held
    do_read();

    // false start: 4-tick low glitch
    line_ticks(1'b1, 2);
    line_ticks(1'b0, 4);
    line_ticks(1'b1, 12);
    @(negedge ACLK);
    rx_sample_pulse = 1'b0;
    check_eq("false_start_idle", 32'(rx_state_dbg), 32'(ST_IDLE));
    check_all("false_start");
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_read();

    // framing error
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-frame while a byte is held
    send_frame(8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    line_ticks(1'b1, 2);
    line_ticks(1'b0, 16);
    line_ticks(1'b1, 20);
    do_reset(2);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // read in the same cycle as a commit
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    do_read();

    // randomized frames
    for (int n = 0; n < 16; n++) begin
      tick_per = $urandom_range(3, 6);
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) do_read();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
